// File: rtl/sd_fifo_pkt.sv
// Packet-aware commit/abort FIFO with srdy/drdy handshakes.
// An eop write commits the packet to the reader. Oversize packets are
// dropped when enabled. The reader can rewind to replay the packet it has
// not yet released.
//
// Write-side FSM states:
//   state  | meaning
//   ACCEPT | words are stored at wr_ptr; c_drdy follows free space
//   DROP   | oversize packet being discarded until its eop word arrives
module sd_fifo_pkt #(
  parameter int width         = 16,
  parameter int depth         = 32,
  parameter bit drop_oversize = 1'b1,
  parameter int asz           = $clog2(depth),
  parameter int usz           = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  input  logic             c_eop,
  input  logic             c_abort,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data,
  output logic             p_eop,
  input  logic             p_abort,
  output logic [usz-1:0]   c_usage,
  output logic [usz-1:0]   p_usage,
  output logic [usz-1:0]   pkt_count,
  output logic [15:0]      drop_cnt
);

  typedef enum logic {ACCEPT, DROP} wr_state_t;

  wr_state_t      wr_state, wr_state_nxt;
  logic [width:0] mem [depth];
  logic [asz-1:0] wr_ptr, wr_com, rd_ptr, rd_com;
  // uncom: words past wr_com; rd_pend: words read but not yet released
  logic [usz-1:0] uncom, rd_pend, p_usage_nxt;
  logic           do_store, do_commit, enter_drop;
  logic           rd_xfer, do_release;

  function automatic logic [asz-1:0] inc_ptr(input logic [asz-1:0] p);
    return (p == asz'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign c_usage         = uncom + p_usage + rd_pend;
  assign p_srdy          = (p_usage != '0);
  assign {p_eop, p_data} = mem[rd_ptr];
  // a rewind in the same cycle cancels the read transfer, including its eop
  assign rd_xfer         = p_srdy & p_drdy & ~p_abort;
  assign do_release      = rd_xfer & p_eop;

  // write FSM next state, c_drdy and write-side control strobes
  always_comb begin
    wr_state_nxt = wr_state;
    c_drdy       = 1'b1;
    do_store     = 1'b0;
    do_commit    = 1'b0;
    enter_drop   = 1'b0;
    case (wr_state)
      ACCEPT: begin
        c_drdy = (c_usage < usz'(depth));
        if (c_srdy && (c_usage < usz'(depth)) && !c_abort) begin
          do_store = 1'b1;
          if (c_eop) begin
            do_commit = 1'b1;
          end else if (drop_oversize && (uncom == usz'(depth - 1))) begin
            enter_drop   = 1'b1;
            wr_state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (c_abort || (c_srdy && c_eop)) wr_state_nxt = ACCEPT;
      end
      default: wr_state_nxt = ACCEPT;
    endcase
  end

  // readable count: add a committed packet, restore a rewind, remove a read
  always_comb begin
    p_usage_nxt = p_usage;
    if (do_commit) p_usage_nxt = p_usage_nxt + uncom + usz'(1);
    if (p_abort)   p_usage_nxt = p_usage_nxt + rd_pend;
    if (rd_xfer)   p_usage_nxt = p_usage_nxt - usz'(1);
  end

  // write FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_state <= ACCEPT;
    else       wr_state <= wr_state_nxt;
  end

  // pointers and occupancy counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      wr_com    <= '0;
      rd_ptr    <= '0;
      rd_com    <= '0;
      uncom     <= '0;
      rd_pend   <= '0;
      p_usage   <= '0;
      pkt_count <= '0;
      drop_cnt  <= '0;
    end else begin
      if (c_abort || enter_drop) wr_ptr <= wr_com;
      else if (do_store)         wr_ptr <= inc_ptr(wr_ptr);
      if (do_commit) wr_com <= inc_ptr(wr_ptr);
      if (c_abort || enter_drop || do_commit) uncom <= '0;
      else if (do_store)                      uncom <= uncom + usz'(1);

      if (p_abort)      rd_ptr <= rd_com;
      else if (rd_xfer) rd_ptr <= inc_ptr(rd_ptr);
      if (do_release) rd_com <= inc_ptr(rd_ptr);
      if (p_abort || do_release) rd_pend <= '0;
      else if (rd_xfer)          rd_pend <= rd_pend + usz'(1);

      p_usage <= p_usage_nxt;
      if (do_commit && !do_release)      pkt_count <= pkt_count + usz'(1);
      else if (!do_commit && do_release) pkt_count <= pkt_count - usz'(1);
      if (enter_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // packet storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (do_store) mem[wr_ptr] <= {c_eop, c_data};
  end

endmodule

// File: tb/tb_sd_fifo_pkt.sv
// Directed bench for sd_fifo_pkt with a scoreboard monitor on the read side.
module tb_sd_fifo_pkt;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_srdy = 1'b0, c_srdy0 = 1'b0;
  logic          c_drdy, c_drdy0;
  logic [W-1:0]  c_data = '0;
  logic          c_eop = 1'b0, c_abort = 1'b0;
  logic          p_srdy, p_srdy0;
  logic          p_drdy = 1'b0, p_abort = 1'b0;
  logic [W-1:0]  p_data, p_data0;
  logic          p_eop, p_eop0;
  logic [5:0]    c_usage, p_usage, pkt_count, c_usage0, p_usage0, pkt_count0;
  logic [15:0]   drop_cnt, drop_cnt0;

  int            checks = 0;
  int            errors = 0;
  logic [16:0]   exp_q[$];
  int            rd_idx = 0;

  sd_fifo_pkt #(.width(16), .depth(32), .drop_oversize(1'b1)) dut (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_eop(c_eop), .c_abort(c_abort),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_eop(p_eop), .p_abort(p_abort),
    .c_usage(c_usage), .p_usage(p_usage), .pkt_count(pkt_count), .drop_cnt(drop_cnt));

  sd_fifo_pkt #(.width(16), .depth(32), .drop_oversize(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy0), .c_drdy(c_drdy0), .c_data(c_data), .c_eop(c_eop), .c_abort(c_abort),
    .p_srdy(p_srdy0), .p_drdy(1'b0), .p_data(p_data0), .p_eop(p_eop0), .p_abort(1'b0),
    .c_usage(c_usage0), .p_usage(p_usage0), .pkt_count(pkt_count0), .drop_cnt(drop_cnt0));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // read-side monitor: a transfer is predicted at the negedge before its edge
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (p_abort) begin
          rd_idx = 0;
        end else if (p_srdy && p_drdy) begin
          checks++;
          if (rd_idx >= exp_q.size()) begin
            errors++;
            $display("FAIL rd_unexpected actual=%h_%h expected=none", p_eop, p_data);
          end else begin
            if ({p_eop, p_data} !== exp_q[rd_idx]) begin
              errors++;
              $display("FAIL rd_word actual=%h_%h expected=%h_%h",
                       p_eop, p_data, exp_q[rd_idx][16], exp_q[rd_idx][15:0]);
            end
            if (exp_q[rd_idx][16]) begin
              repeat (rd_idx + 1) void'(exp_q.pop_front());
              rd_idx = 0;
            end else begin
              rd_idx++;
            end
          end
        end
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the word transferred
  task automatic put(input logic [W-1:0] d, input logic e);
    int n = 0;
    c_srdy = 1'b1; c_data = d; c_eop = e;
    @(negedge clk);
    while (!c_drdy && n < 200) begin n++; @(negedge clk); end
    if (!c_drdy) chk("put_timeout", 0, 1);
    @(posedge clk); #1;
    c_srdy = 1'b0; c_eop = 1'b0;
  endtask

  task automatic send_pkt(input logic [W-1:0] base, input int len, input bit push);
    if (push)
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), base + W'(i)});
    for (int i = 0; i < len; i++) put(base + W'(i), (i == len - 1));
  endtask

  task automatic read_n(input int n);
    p_drdy = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    p_drdy = 1'b0;
  endtask

  task automatic drain(input logic [7:0] pat, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      p_drdy = pat[i % 8];
      @(posedge clk); #1;
      i++;
    end
    p_drdy = 1'b0;
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic pulse(input bit rd_side);
    if (rd_side) p_abort = 1'b1; else c_abort = 1'b1;
    @(posedge clk); #1;
    p_abort = 1'b0; c_abort = 1'b0;
  endtask

  initial begin
    int acc, stall;
    // async reset, checked before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_c_drdy", c_drdy, 1);
    chk("rst_p_srdy", p_srdy, 0);
    chk("rst_c_usage", c_usage, 0);
    chk("rst_p_usage", p_usage, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // four 8-word packets fill the FIFO, then read with drdy pattern 0xA5
    for (int p = 0; p < 4; p++) send_pkt(16'h0100 + 16'(p * 16), 8, 1'b1);
    chk("t1_pkt_count", pkt_count, 4);
    chk("t1_c_usage", c_usage, 32);
    chk("t1_p_usage", p_usage, 32);
    chk("t1_c_drdy_full", c_drdy, 0);
    drain(8'hA5, 300);
    chk("t1_pkt_count_end", pkt_count, 0);
    chk("t1_c_usage_end", c_usage, 0);
    chk("t1_drop_cnt", drop_cnt, 0);
    chk("t1_p_srdy_end", p_srdy, 0);

    // write abort
    for (int i = 0; i < 5; i++) put(16'hDEA0 + 16'(i), 1'b0);
    chk("t2_p_srdy", p_srdy, 0);
    chk("t2_c_usage", c_usage, 5);
    chk("t2_p_usage", p_usage, 0);
    pulse(1'b0);
    chk("t2_c_usage_abort", c_usage, 0);
    chk("t2_c_drdy", c_drdy, 1);
    send_pkt(16'h0200, 3, 1'b1);
    drain(8'hFF, 50);
    chk("t2_pkt_count", pkt_count, 0);

    // read replay, including a rewind coincident with the eop transfer
    send_pkt(16'h0300, 10, 1'b1);
    read_n(6);
    chk("t3_p_usage_part", p_usage, 4);
    chk("t3_c_usage_part", c_usage, 10);
    pulse(1'b1);
    chk("t3_p_usage_rewind", p_usage, 10);
    read_n(9);
    p_drdy = 1'b1; p_abort = 1'b1;
    @(posedge clk); #1;
    p_drdy = 1'b0; p_abort = 1'b0;
    chk("t3_p_usage_eop_abort", p_usage, 10);
    chk("t3_pkt_count_held", pkt_count, 1);
    drain(8'hFF, 50);
    chk("t3_c_usage_end", c_usage, 0);
    chk("t3_pkt_count_end", pkt_count, 0);

    // oversize drop
    for (int i = 0; i < 32; i++) put(16'h0E00 + 16'(i), 1'b0);
    chk("t4_c_usage_drop", c_usage, 0);
    chk("t4_drop_cnt_entry", drop_cnt, 1);
    chk("t4_c_drdy_drop", c_drdy, 1);
    for (int i = 32; i < 40; i++) put(16'h0E00 + 16'(i), (i == 39));
    chk("t4_p_srdy", p_srdy, 0);
    chk("t4_pkt_count", pkt_count, 0);
    chk("t4_drop_cnt", drop_cnt, 1);
    send_pkt(16'h0400, 4, 1'b1);
    drain(8'hFF, 50);
    chk("t4_c_usage_end", c_usage, 0);

    // no-drop instance stalls on the oversize packet
    acc = 0; stall = 0;
    c_srdy0 = 1'b1; c_eop = 1'b0;
    repeat (140) begin
      @(negedge clk);
      if (c_drdy0) begin acc++; stall = 0; end else stall++;
      @(posedge clk); #1;
    end
    c_srdy0 = 1'b0;
    chk("t5_accepted", acc, 32);
    chk("t5_stall_ge_100", int'(stall >= 100), 1);
    chk("t5_c_usage0", c_usage0, 32);
    chk("t5_drop_cnt0", drop_cnt0, 0);
    pulse(1'b0);
    chk("t5_c_usage0_abort", c_usage0, 0);

    // full with stalled reader, then release reopens the write side
    for (int p = 0; p < 3; p++) send_pkt(16'h0500 + 16'(p * 16), 10, 1'b1);
    chk("t6_c_usage_30", c_usage, 30);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 16'h0600 + 16'(i)});
    put(16'h0600, 1'b0);
    put(16'h0601, 1'b0);
    chk("t6_c_drdy_full", c_drdy, 0);
    chk("t6_c_usage_full", c_usage, 32);
    read_n(9);
    chk("t6_c_drdy_before_eop", c_drdy, 0);
    read_n(1);
    chk("t6_c_drdy_after_eop", c_drdy, 1);
    chk("t6_c_usage_after_eop", c_usage, 22);
    put(16'h0602, 1'b0);
    put(16'h0603, 1'b1);
    drain(8'hFF, 300);
    chk("t6_c_usage_end", c_usage, 0);
    chk("t6_pkt_count_end", pkt_count, 0);

    // reset mid-packet on both sides
    send_pkt(16'h0800, 6, 1'b1);
    read_n(3);
    put(16'h0900, 1'b0);
    put(16'h0901, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t7_c_drdy", c_drdy, 1);
    chk("t7_p_srdy", p_srdy, 0);
    chk("t7_c_usage", c_usage, 0);
    chk("t7_p_usage", p_usage, 0);
    chk("t7_pkt_count", pkt_count, 0);
    chk("t7_drop_cnt", drop_cnt, 0);
    exp_q.delete();
    rd_idx = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_pkt(16'h0A00, 3, 1'b1);
    drain(8'hFF, 50);
    chk("t7_p_usage_end", p_usage, 0);
    chk("t7_pkt_count_end", pkt_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_fifo_pkt.md
# sd_fifo_pkt

Packet-aware commit/abort FIFO in the sd srdy/drdy handshake family. It is the successor to the word-level commit/abort FIFO. Commit is driven by an end-of-packet marker instead of a level-sensitive commit input. Oversize packets are dropped automatically, and the read side can replay the current packet. It sits between packet producers (parsers, DMA engines) and consumers that may need to re-read or discard a partially consumed packet.

## Interface
- width, 16, data bits per word
- depth, 32, storage words (any value ≥ 4, not restricted to powers of 2)
- drop_oversize, 1, 1 = drop packets larger than depth; 0 = backpressure indefinitely
- asz, $clog2(depth), pointer width (derived)
- usz, $clog2(depth+1), usage width (derived)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- c_srdy  in  1  write word valid
- c_drdy  out  1  write word accepted
- c_data  in  width  write data
- c_eop  in  1  last word of packet; commits packet on transfer
- c_abort  in  1  discard uncommitted write words
- p_srdy  out  1  read word valid
- p_drdy  in  1  read word taken
- p_data  out  width  read data
- p_eop  out  1  last word of packet
- p_abort  in  1  rewind read to start of unreleased packet
- c_usage  out  usz  words held from rd_com up to wr_ptr (includes uncommitted and unreleased words)
- p_usage  out  usz  committed words from rd_ptr up to wr_com
- pkt_count  out  usz  committed packets not yet released
- drop_cnt  out  16  oversize packets dropped, saturating

## Operation
- Storage: flop array of width+1 bits (data plus eop). Storage is not reset.
- Four pointers, each wrapping from depth-1 to 0:
  - wr_ptr: speculative write
  - wr_com: committed write
  - rd_ptr: speculative read
  - rd_com: released read
- Occupancy is held in counters, not derived from pointer differences, so full and empty are unambiguous at any depth.
- Write transfer occurs when c_srdy and c_drdy are both high. The word is stored at wr_ptr and wr_ptr advances.
- A write transfer with c_eop high sets wr_com to wr_ptr+1 and increments pkt_count.
- c_abort sets wr_ptr to wr_com. If a transfer occurs in the same cycle, abort wins and the word is discarded, including any eop.
- c_drdy = (c_usage < depth) in ACCEPT, and 1 in DROP.
- Write FSM, ACCEPT → DROP: entered when drop_oversize=1 and uncommitted words (wr_ptr − wr_com) reach depth. On entry:
  - wr_ptr is set to wr_com
  - drop_cnt increments
- In DROP, words are accepted and discarded. The eop word transfer returns the FSM to ACCEPT.
- c_abort in DROP returns the FSM to ACCEPT. drop_cnt is not changed again.
- With drop_oversize=0, an oversize packet stalls with c_drdy=0. This is defined behaviour.
- Read side:
  - p_srdy = (p_usage ≠ 0)
  - p_data and p_eop are driven combinationally from storage at rd_ptr
  - a read transfer advances rd_ptr
- Read transfer with p_eop high sets rd_com to rd_ptr+1 and decrements pkt_count (auto release).
- p_abort sets rd_ptr to rd_com, replaying the packet. If an eop transfer occurs in the same cycle, abort wins: the packet is not released and replays from its first word.
- Write-side and read-side events are independent in any combination. If a commit and a release occur in the same cycle, pkt_count is unchanged.

## Timing
- Reset values:
  - c_drdy=1, p_srdy=0
  - c_usage, p_usage, pkt_count, drop_cnt = 0
  - FSM in ACCEPT, all pointers 0
  - p_data and p_eop are don't-care while p_srdy=0
- Commit latency: an eop written at edge N makes p_srdy=1 in the cycle after edge N.
- Abort latency: c_abort sampled at edge N; c_usage reflects the rewind and c_drdy=1 after edge N.
- Release latency: an eop read at edge N frees words; c_drdy can reassert after edge N.
- p_abort sampled at edge N; p_usage is restored after edge N.
- drop_cnt saturates at 0xFFFF.
- Reset asserted mid-packet clears state immediately, without waiting for a clock edge.

## Test plan
- Four 8-word packets, read with drdy pattern 0xA5: all 32 words arrive in order, p_eop on words 7/15/23/31, pkt_count returns to 0, drop_cnt=0.
- Write 5 words with no eop: p_srdy=0, c_usage=5, p_usage=0. Pulse c_abort: c_usage=0 next cycle. Send a 3-word packet: only those 3 words are delivered.
- Commit a 10-word packet, read 6 words, pulse p_abort: p_usage=10. All 10 words are re-read identically. After the eop, c_usage=0 and pkt_count=0. Also cover p_abort coincident with the eop transfer: the packet replays a third time.
- drop_oversize=1, 40-word packet: after 32 words the FSM enters DROP and the remaining 8 are accepted. drop_cnt=1 and nothing appears on the read side. The following 4-word packet is delivered intact.
- drop_oversize=0, same packet: c_drdy stays 0 with c_usage=32 for 100 cycles.
- Three committed 10-word packets with the reader stalled, then a 4th packet: 2 words are accepted, then c_drdy=0 at c_usage=32. Drain the first packet: c_drdy=1 the cycle after its eop is read, and pointers wrap correctly.
- Assert reset mid-packet on both sides: outputs go to reset values immediately. After release, a fresh packet is delivered with no stale words.
